dram_refresh_request: RTL and testbench

//  Consumes PIT counter 1 output (counter_1_out, ~15 us period in PC/XT mode 2) and turns each rising

---
 rtl/kf_chipset_pkg.sv | 22 ++
 rtl/sync_rise_detect.sv | 62 ++++++
 rtl/dram_refresh_request.sv | 175 +++++++++++++++++
 tb/tb_dram_refresh_request.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/kf_chipset_pkg.sv
// ---------------------------------------------------------------------------
// kf_chipset_pkg
// Shared definitions for the KFPC-XT chipset blocks.
//   - refresh_state_t : state encoding of the DRAM refresh request FSM
//   - DEFAULT_TIMEOUT_CYCLES : clocks a refresh request may wait for DACK0
//   - PIT_CH_* : role of each 8253 channel on the XT board
// ---------------------------------------------------------------------------
package kf_chipset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_ACKED   = 2'd2
    } refresh_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    localparam int PIT_CH_SYSTEM_TIMER = 0;
    localparam int PIT_CH_DRAM_REFRESH = 1;
    localparam int PIT_CH_SPEAKER      = 2;

endpackage

// File: rtl/sync_rise_detect.sv
// ---------------------------------------------------------------------------
// sync_rise_detect
// Brings the PIT counter 1 output into the clock domain through SYNC_STAGES
// flops (0, 2 or 3), then compares against an edge register and emits a
// registered one-cycle pulse for every rising edge.
// Ports:
//   clock     in  system clock
//   reset     in  synchronous, active-high
//   timer_out in  raw PIT counter 1 output
//   rise      out one-cycle pulse, SYNC_STAGES+1 clocks after timer_out is
//                 first sampled high
// ---------------------------------------------------------------------------
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic timer_out,
    output logic rise
);

    logic sync_out;
    logic sync_q;

    // With zero stages the input is assumed already synchronous, otherwise
    // it ripples through a plain shift chain whose last flop is the
    // synchronised level.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync_out = timer_out;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;

            always_ff @(posedge clock) begin
                if (reset) begin
                    chain <= '0;
                end else begin
                    chain[0] <= timer_out;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign sync_out = chain[SYNC_STAGES-1];
        end
    endgenerate

    // The edge register starts at 0, so a level already high when reset is
    // released is reported as a rising edge. The pulse itself is registered
    // so the consumer sees a clean flop output.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= sync_out;
            rise   <= sync_out & ~sync_q;
        end
    end

endmodule

// File: rtl/dram_refresh_request.sv
// ---------------------------------------------------------------------------
// dram_refresh_request
// Turns each rising edge of PIT counter 1 into a DREQ0 refresh request for
// the 8237 DMA controller and holds it until DACK0 completes the handshake.
// Edges arriving while a request is outstanding are counted, lost edges and
// abandoned requests are flagged in sticky status bits.
// Ports:
//   clock          in  system clock
//   reset          in  synchronous, active-high
//   timer_out      in  PIT counter 1 output
//   refresh_enable in  1 = generate requests, 0 = flush and idle
//   dma_ack_n      in  DACK0, active low
//   error_clear    in  pulse clearing overrun/timeout
//   dma_request    out DREQ0, high exactly while in REQUEST
//   pending_count  out edges not yet serviced, including the one in flight
//   refresh_strobe out one-cycle pulse per completed acknowledge
//   overrun        out sticky: edge arrived with pending_count saturated
//   timeout        out sticky: request abandoned without DACK0
// ---------------------------------------------------------------------------
module dram_refresh_request
    import kf_chipset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PENDING_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     timer_out,
    input  logic                     refresh_enable,
    input  logic                     dma_ack_n,
    input  logic                     error_clear,
    output logic                     dma_request,
    output logic [PENDING_WIDTH-1:0] pending_count,
    output logic                     refresh_strobe,
    output logic                     overrun,
    output logic                     timeout
);

    localparam int                     WAIT_WIDTH   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_WIDTH-1:0]    WAIT_LAST    = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PENDING_WIDTH-1:0] PENDING_MAX  = {PENDING_WIDTH{1'b1}};

    refresh_state_t          state;
    refresh_state_t          state_next;
    logic [WAIT_WIDTH-1:0]   wait_count;
    logic                    rise;
    logic                    edge_accept;
    logic                    ack_event;
    logic                    timeout_event;
    logic                    overrun_event;
    logic                    leave_request;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rise_detect (
        .clock     (clock),
        .reset     (reset),
        .timer_out (timer_out),
        .rise      (rise)
    );

    assign edge_accept   = rise & refresh_enable;
    assign leave_request = ack_event | timeout_event;
    assign overrun_event = edge_accept & (pending_count == PENDING_MAX);
    assign dma_request   = (state == ST_REQUEST);

    // State register for the request handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request handshake. An acknowledge beats both a disable and a timeout in
    // the same cycle, so a DMA cycle that really happened is always counted.
    // DACK0 low while idle belongs to some other DMA use and is ignored; a
    // request is only raised once DACK0 is released, which also guarantees
    // an idle cycle between back-to-back requests.
    always_comb begin
        state_next    = state;
        ack_event     = 1'b0;
        timeout_event = 1'b0;
        case (state)
            ST_IDLE: begin
                if (refresh_enable && (pending_count != '0) && dma_ack_n) begin
                    state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (!dma_ack_n) begin
                    state_next = ST_ACKED;
                    ack_event  = 1'b1;
                end else if (!refresh_enable) begin
                    state_next = ST_IDLE;
                end else if (wait_count == WAIT_LAST) begin
                    state_next    = ST_IDLE;
                    timeout_event = 1'b1;
                end
            end
            ST_ACKED: begin
                if (dma_ack_n) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counts how long the current request has waited for DACK0; it is held
    // at zero outside REQUEST so each request starts a fresh wait.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count <= '0;
        end else if (state != ST_REQUEST) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + WAIT_WIDTH'(1);
        end
    end

    // Pending edge counter. Disabling refresh flushes everything. A new edge
    // and a completed request in the same cycle cancel out; the counter
    // saturates at the top and never goes below zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_count <= '0;
        end else if (!refresh_enable) begin
            pending_count <= '0;
        end else begin
            case ({edge_accept, leave_request})
                2'b10: begin
                    if (pending_count != PENDING_MAX) begin
                        pending_count <= pending_count + PENDING_WIDTH'(1);
                    end
                end
                2'b01: begin
                    if (pending_count != '0) begin
                        pending_count <= pending_count - PENDING_WIDTH'(1);
                    end
                end
                default: begin
                    pending_count <= pending_count;
                end
            endcase
        end
    end

    // Completion strobe and sticky status. A flag being set wins over a
    // clear arriving in the same cycle so no event can slip through.
    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_strobe <= 1'b0;
            overrun        <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            refresh_strobe <= ack_event;
            if (overrun_event) begin
                overrun <= 1'b1;
            end else if (error_clear) begin
                overrun <= 1'b0;
            end
            if (timeout_event) begin
                timeout <= 1'b1;
            end else if (error_clear) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dram_refresh_request.sv
// ---------------------------------------------------------------------------
// tb_dram_refresh_request
// Directed bench for dram_refresh_request with default parameters
// (SYNC_STAGES=2, PENDING_WIDTH=2, TIMEOUT_CYCLES=256). Inputs change 1 ns
// after a rising clock edge and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_dram_refresh_request;
    import kf_chipset_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       timer_out;
    logic       refresh_enable;
    logic       dma_ack_n;
    logic       error_clear;
    logic       dma_request;
    logic [1:0] pending_count;
    logic       refresh_strobe;
    logic       overrun;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    dram_refresh_request dut (
        .clock          (clock),
        .reset          (reset),
        .timer_out      (timer_out),
        .refresh_enable (refresh_enable),
        .dma_ack_n      (dma_ack_n),
        .error_clear    (error_clear),
        .dma_request    (dma_request),
        .pending_count  (pending_count),
        .refresh_strobe (refresh_strobe),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic tmr, input logic en,
                                 input logic ack_n, input logic clr);
        reset          = rst;
        timer_out      = tmr;
        refresh_enable = en;
        dma_ack_n      = ack_n;
        error_clear    = clr;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic req, input logic [1:0] pend,
                               input logic strb, input logic ovr, input logic tmo);
        checkOne({tag, ".dma_request"},    32'(dma_request),    32'(req));
        checkOne({tag, ".pending_count"},  32'(pending_count),  32'(pend));
        checkOne({tag, ".refresh_strobe"}, 32'(refresh_strobe), 32'(strb));
        checkOne({tag, ".overrun"},        32'(overrun),        32'(ovr));
        checkOne({tag, ".timeout"},        32'(timeout),        32'(tmo));
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkOne("reset.state", 32'(dut.state), 32'(ST_IDLE));

        // Single rise, acknowledged three clocks after the request
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("t1.k2", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t1.k3", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t1.k4", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("t1.hold", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t1.ack", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        checkOne("t1.state_acked", 32'(dut.state), 32'(ST_ACKED));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t1.release", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkOne("t1.state_idle", 32'(dut.state), 32'(ST_IDLE));

        // Four rises without ack: saturate at 3 and flag overrun, then drain
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            tick();
            tick();
            checkOutput("t2.rise", (i > 0), (i < 3) ? 2'(i + 1) : 2'd3, 1'b0, (i == 3), 1'b0);
        end
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            checkOutput("t2.ack", 1'b0, 2'(2 - j), 1'b1, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput("t2.release", 1'b0, 2'(2 - j), 1'b0, 1'b1, 1'b0);
            tick();
            checkOutput("t2.next", (j < 2), 2'(2 - j), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t2.clear", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // No ack: request abandoned after 256 clocks
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t3.start", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) tick();
        checkOutput("t3.last", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t3.timeout", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3.clear", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Rise counted in the same cycle as the ack: pending stays at 1
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t4.request", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("t4.before", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t4.ack", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t4.release", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t4.rerequest", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);

        // Disable during REQUEST, then rises are ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t5.disable", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t5.ignored", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("t5.reenable", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Reset while in ACKED
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t6.two_pending", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t6.acked", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t6.reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkOne("t6.state", 32'(dut.state), 32'(ST_IDLE));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t6.after", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
